board_init_seq: RTL and testbench

- Sequences initialisation of the minesweeper board memory before each game.
- Clear phase: zeroes every cell.
- Place phase: places NUM_MINES mines at distinct pseudo-random cells, using a free-running LFSR with read-check-write against the board RAM.
- Raises a one-cycle `done` pulse, which drives the game controller's ultima_casilla input. Sits between the start/reset logic and the board RAM, and owns the RAM port while busy.

---
 rtl/board_init_seq.sv | 196 +++++++++++++++++++
 tb/tb_board_init_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_init_seq.sv
// board_init_seq
//   Prepares the minesweeper board RAM before each game. On an accepted start it
//   first zeroes every cell. It then places NUM_MINES mines at distinct
//   pseudo-random cells. A free-running LFSR supplies candidate cells. Each
//   in-range candidate is read back from the RAM, and it is written only if the
//   cell is still empty. A one-cycle done pulse marks a ready board. This pulse
//   feeds the game controller's ultima_casilla input. The block owns the RAM
//   port while busy.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start         level-sampled request, honoured only when idle
//   mem_addr      board RAM address, row-major (row*COLS+col)
//   mem_we        board RAM write enable
//   mem_wdata     mine bit to write
//   mem_rdata     mine bit at the address driven on the previous cycle
//   busy          high from the first clear cycle through the done cycle
//   done          one-cycle pulse when the board is ready
//   mines_placed  mines written in the current sequence
module board_init_seq #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned NUM_MINES = 10,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [7:0]  SEED      = 8'h2D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   mines_placed
);

  localparam int unsigned Cells = ROWS * COLS;

  // All address/count comparisons are one bit wider than the address so that a
  // board filling the whole address space does not wrap.
  localparam logic [ADDR_W:0]   CellsW   = (ADDR_W + 1)'(Cells);
  localparam logic [ADDR_W:0]   LastW    = (ADDR_W + 1)'(Cells - 1);
  localparam logic [ADDR_W:0]   MinesW   = (ADDR_W + 1)'(NUM_MINES);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

  // Elaboration-time parameter sanity.
  if (NUM_MINES < 1 || NUM_MINES >= Cells) begin : g_bad_mines
    $error("board_init_seq: NUM_MINES must satisfy 1 <= NUM_MINES < ROWS*COLS");
  end
  if ((64'd1 << ADDR_W) < 64'(Cells)) begin : g_bad_addr_w
    $error("board_init_seq: ADDR_W too narrow for ROWS*COLS");
  end
  if (ADDR_W > 8) begin : g_bad_addr_lfsr
    $error("board_init_seq: candidates come from an 8-bit LFSR, ADDR_W must be <= 8");
  end
  if (SEED == 8'h00) begin : g_bad_seed
    $error("board_init_seq: SEED must be nonzero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPick,
    StRead,
    StCheck,
    StWrite,
    StDone
  } state_e;

  state_e            state_q;
  logic [7:0]        lfsr_q;
  logic [7:0]        lfsr_next;
  logic [ADDR_W-1:0] cand_q;
  logic [ADDR_W-1:0] cand_new;
  logic              rdata_q;
  logic [ADDR_W:0]   count_inc;

  // Galois LFSR, shift right, feedback mask 8'hB8.
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  assign cand_new  = lfsr_q[ADDR_W-1:0];
  assign count_inc = mines_placed + CountOne;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      lfsr_q       <= SEED;
      cand_q       <= '0;
      rdata_q      <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mines_placed <= '0;
    end else begin
      // Free-running in every state so that the user's start timing adds entropy.
      lfsr_q <= lfsr_next;
      done   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          if (start) begin
            state_q      <= StClear;
            mem_addr     <= '0;
            mem_we       <= 1'b1;
            mem_wdata    <= 1'b0;
            busy         <= 1'b1;
            mines_placed <= '0;
          end
        end

        StClear: begin
          if ({1'b0, mem_addr} == LastW) begin
            state_q  <= StPick;
            mem_we   <= 1'b0;
            cand_q   <= cand_new;
            mem_addr <= cand_new;
          end else begin
            mem_addr <= mem_addr + AddrOne;
          end
        end

        StPick: begin
          if ({1'b0, cand_q} >= CellsW) begin
            // Off the board: draw again without touching the RAM.
            cand_q   <= cand_new;
            mem_addr <= cand_new;
          end else begin
            state_q <= StRead;
          end
        end

        StRead: begin
          rdata_q <= mem_rdata;
          state_q <= StCheck;
        end

        StCheck: begin
          if (rdata_q) begin
            state_q  <= StPick;
            cand_q   <= cand_new;
            mem_addr <= cand_new;
          end else begin
            state_q   <= StWrite;
            mem_we    <= 1'b1;
            mem_wdata <= 1'b1;
          end
        end

        StWrite: begin
          mem_we       <= 1'b0;
          mem_wdata    <= 1'b0;
          mines_placed <= count_inc;
          if (count_inc == MinesW) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            state_q  <= StPick;
            cand_q   <= cand_new;
            mem_addr <= cand_new;
          end
        end

        StDone: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          mem_addr <= '0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The RAM is only ever written while clearing or while placing a mine.
  a_we_states: assert property (@(posedge clk) disable iff (!rst)
    mem_we |-> (state_q == StClear || state_q == StWrite));

  a_count_max: assert property (@(posedge clk) disable iff (!rst)
    mines_placed <= MinesW);

  a_done_busy: assert property (@(posedge clk) disable iff (!rst)
    done |-> busy);

endmodule

// File: tb/tb_board_init_seq.sv
module tb_board_init_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start_s = 1'b0;

  // Default 8x8 board, 10 mines.
  logic [5:0] mem_addr;
  logic       mem_we, mem_wdata, busy, done;
  logic       mem_rdata;
  logic [6:0] mines_placed;

  // 5x5 board, 24 mines.
  logic [4:0] s_addr;
  logic       s_we, s_wdata, s_busy, s_done;
  logic       s_rdata;
  logic [5:0] s_mines;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_init_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .mines_placed (mines_placed)
  );

  board_init_seq #(
    .ROWS      (5),
    .COLS      (5),
    .NUM_MINES (24),
    .ADDR_W    (5)
  ) dut_s (
    .clk          (clk),
    .rst          (rst),
    .start        (start_s),
    .mem_addr     (s_addr),
    .mem_we       (s_we),
    .mem_wdata    (s_wdata),
    .mem_rdata    (s_rdata),
    .busy         (s_busy),
    .done         (s_done),
    .mines_placed (s_mines)
  );

  // Edges seen since reset release; the LFSR has advanced exactly this many times.
  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Behavioural RAMs with one-cycle read latency. A preloaded "sticky" cell keeps
  // its 1 through the clear phase.
  logic ram   [64] = '{default: 1'b0};
  logic ram_s [32] = '{default: 1'b0};
  int   stk_addr = -1;
  bit   pre_en = 1'b0;

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (pre_en) ram[stk_addr[5:0]] <= 1'b1;
    else if (mem_we && !(int'(mem_addr) == stk_addr && !mem_wdata)) ram[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    s_rdata <= ram_s[s_addr];
    if (s_we) ram_s[s_addr] <= s_wdata;
  end

  // Monitors: mine writes with their cycle, done pulses, off-board writes.
  int act_c[$], act_a[$], sact_c[$], sact_a[$];
  int ndone = 0, s_ndone = 0, s_oob = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we && mem_wdata) begin act_c.push_back(cyc); act_a.push_back(int'(mem_addr)); end
      if (s_we && s_wdata) begin sact_c.push_back(cyc); sact_a.push_back(int'(s_addr)); end
      if (done) ndone <= ndone + 1;
      if (s_done) s_ndone <= s_ndone + 1;
      if (s_we && s_addr >= 5'd25) s_oob <= s_oob + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l;
    l = 8'h2D;
    for (int i = 0; i < n; i++) l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    return l;
  endfunction

  // Reference model: start seen in the idle cycle s, clear takes `cells` cycles,
  // then each candidate costs 1 (off board), 3 (already mined) or 4 (placed)
  // cycles. A candidate examined in cycle c is the LFSR value of cycle c-1.
  int exp_c[$], exp_a[$];
  int exp_done;
  bit mram[64];

  task automatic run_model(input int s, input int cells, input int aw, input int nm);
    int c, cnt, cand;
    exp_c.delete();
    exp_a.delete();
    c   = s + cells + 1;
    cnt = 0;
    while (cnt < nm && c < s + 20000) begin
      cand = int'(lfsr_at(c - 1)) & ((1 << aw) - 1);
      if (cand >= cells) c += 1;
      else if (mram[cand]) c += 3;
      else begin
        mram[cand] = 1'b1;
        exp_c.push_back(c + 3);
        exp_a.push_back(cand);
        cnt++;
        c += 4;
      end
    end
    exp_done = c;
  endtask

  task automatic big_run(input bit preload, input bit noise, input bit hold);
    int s, n0, w0, guard, first, pop, dups;
    repeat ($urandom_range(1, 8)) @(negedge clk);
    s  = cyc;
    n0 = ndone;
    w0 = act_c.size();
    for (int i = 0; i < 64; i++) mram[i] = 1'b0;
    stk_addr = -1;
    if (preload) begin
      first = int'(lfsr_at(s + 64)) & 63;
      mram[first] = 1'b1;
      stk_addr = first;
      pre_en = 1'b1;
    end
    run_model(s, 64, 6, 10);
    start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      pre_en = 1'b0;
      start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      check("clear", 32'({busy, mem_we, mem_wdata, mem_addr}), 32'({3'b110, 6'(k)}));
    end
    @(negedge clk);
    check("pick_we", 32'({busy, mem_we}), 32'd2);
    guard = 0;
    while (cyc < exp_done && guard < 20000) begin
      if (!hold) start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      guard++;
    end
    if (!hold) start = 1'b0;
    check("done_cyc", 32'(cyc), 32'(exp_done));
    check("done_hi", 32'({done, busy, mines_placed}), 32'({2'b11, 7'd10}));
    @(negedge clk);
    check("done_lo", 32'({done, busy, mines_placed}), 32'({2'b00, 7'd10}));
    check("done_cnt", 32'(ndone - n0), 32'd1);
    check("wr_cnt", 32'(act_c.size() - w0), 32'(exp_c.size()));
    foreach (exp_c[i]) begin
      check("wr_seq", (w0 + i < act_c.size()) ? 32'((act_c[w0 + i] << 8) | act_a[w0 + i])
                                              : 32'hFFFF_FFFF, 32'((exp_c[i] << 8) | exp_a[i]));
    end
    dups = 0;
    for (int i = w0; i < act_a.size(); i++)
      for (int j = i + 1; j < act_a.size(); j++)
        if (act_a[i] == act_a[j]) dups++;
    check("wr_distinct", 32'(dups), 32'd0);
    pop = 0;
    for (int i = 0; i < 64; i++) if (ram[i] === 1'b1) pop++;
    check("popcount", 32'(pop), 32'(10 + int'(preload)));
    if (hold) begin
      @(negedge clk);
      check("retrigger", 32'({busy, mem_we, mem_addr, mines_placed}), 32'({2'b11, 13'd0}));
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, n0, w0, guard, pop, freec;

    // Reset holds every output low whatever start does.
    repeat (4) begin
      @(negedge clk);
      start   = 1'($urandom_range(0, 1));
      start_s = 1'($urandom_range(0, 1));
      check("rst_out", 32'({mem_addr, mem_we, mem_wdata, busy, done, mines_placed}), 32'd0);
      check("rst_out_s", 32'({s_addr, s_we, s_wdata, s_busy, s_done, s_mines}), 32'd0);
    end
    start   = 1'b0;
    start_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    big_run(1'b0, 1'b0, 1'b0);   // plain run
    big_run(1'b1, 1'b1, 1'b0);   // first candidate already mined, start noise while busy

    // Abort after five mines.
    repeat ($urandom_range(1, 5)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (mines_placed != 7'd5 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_at5", 32'(mines_placed), 32'd5);
    #2 rst = 1'b0;
    #1 check("abort_out", 32'({mem_addr, mem_we, mem_wdata, busy, done, mines_placed}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    big_run(1'b0, 1'b0, 1'b0);   // fresh sequence after abort
    big_run(1'b0, 1'b0, 1'b1);   // start held high re-triggers

    // 5x5 board with 24 mines.
    repeat ($urandom_range(1, 8)) @(negedge clk);
    s  = cyc;
    n0 = s_ndone;
    w0 = sact_c.size();
    for (int i = 0; i < 64; i++) mram[i] = 1'b0;
    run_model(s, 25, 5, 24);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check("s_busy", 32'(s_busy), 32'd1);
    guard = 0;
    while (cyc < exp_done && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("s_done_cyc", 32'(cyc), 32'(exp_done));
    check("s_done_hi", 32'({s_done, s_busy, s_mines}), 32'({2'b11, 6'd24}));
    @(negedge clk);
    check("s_done_lo", 32'({s_done, s_busy, s_mines}), 32'({2'b00, 6'd24}));
    check("s_done_cnt", 32'(s_ndone - n0), 32'd1);
    check("s_wr_cnt", 32'(sact_c.size() - w0), 32'(exp_c.size()));
    foreach (exp_c[i]) begin
      check("s_wr_seq", (w0 + i < sact_c.size()) ? 32'((sact_c[w0 + i] << 8) | sact_a[w0 + i])
                                                 : 32'hFFFF_FFFF, 32'((exp_c[i] << 8) | exp_a[i]));
    end
    check("s_oob", 32'(s_oob), 32'd0);
    pop   = 0;
    freec = 0;
    for (int i = 0; i < 25; i++) begin
      if (ram_s[i] === 1'b1) pop++;
      if (ram_s[i] === 1'b0) freec++;
    end
    check("s_popcount", 32'(pop), 32'd24);
    check("s_free", 32'(freec), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
